mdu_ctrl: RTL



---
 rtl/mdu_ctrl.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_ctrl
//  Brief    : Multiply/divide sequencing controller. Accepts mult/multu/
//             div/divu/mthi/mtlo from Execute, holds busy for a fixed
//             per-operation latency, commits HI/LO, and abandons in-flight
//             work on a pipeline flush.
//  Revision : 1.0  initial release
// ============================================================================
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,   // busy cycles for mult/multu (1..15)
    parameter int DIV_CYCLES  = 10   // busy cycles for div/divu   (1..15)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

    localparam logic [3:0] c_MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_LOAD  = 4'(DIV_CYCLES);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_wr;     // 0 for divide-by-zero: commit leaves HI/LO alone
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [0:0]  w_state_next;
    logic        w_accept;
    logic        w_commit;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_div_signed;
    logic [3:0]  w_cnt_load;

    logic [63:0] w_smul;
    logic [63:0] w_umul;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_wr;

    assign w_is_mul     = (op == c_OP_MULT) || (op == c_OP_MULTU);
    assign w_is_div     = (op == c_OP_DIV)  || (op == c_OP_DIVU);
    assign w_div_signed = (op == c_OP_DIV);
    assign w_cnt_load   = w_is_mul ? c_MULT_LOAD : c_DIV_LOAD;

    // ------------------------------------------------------------------------
    // Arithmetic. Division works on magnitudes so the most-negative dividend
    // divided by -1 wraps to 0x80000000 without relying on signed overflow
    // behaviour. A zero divisor is replaced by 1 only to keep the operator
    // well defined; that result is never written back.
    // ------------------------------------------------------------------------
    assign w_smul    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_umul    = {32'd0, a} * {32'd0, b};

    assign w_mag_a   = (w_div_signed && a[31]) ? (~a + 32'd1) : a;
    assign w_mag_b   = (w_div_signed && b[31]) ? (~b + 32'd1) : b;
    assign w_divisor = (b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_q_mag   = w_mag_a / w_divisor;
    assign w_r_mag   = w_mag_a % w_divisor;

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign w_quot    = (w_div_signed && (a[31] ^ b[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem     = (w_div_signed && a[31])           ? (~w_r_mag + 32'd1) : w_r_mag;

    // Select the 64-bit result to be parked until the commit edge.
    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_res_wr = 1'b0;
        case (op)
            c_OP_MULT: begin
                w_res_hi = w_smul[63:32];
                w_res_lo = w_smul[31:0];
                w_res_wr = 1'b1;
            end
            c_OP_MULTU: begin
                w_res_hi = w_umul[63:32];
                w_res_lo = w_umul[31:0];
                w_res_wr = 1'b1;
            end
            c_OP_DIV, c_OP_DIVU: begin
                w_res_hi = w_rem;
                w_res_lo = w_quot;
                w_res_wr = (b != 32'd0);
            end
            default: begin
                w_res_wr = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: flush beats everything, then acceptance / final count.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start && !flush && (w_is_mul || w_is_div)) begin
                    w_state_next = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (flush || (r_cnt == 4'd1)) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Control outputs: accept/move strobes in IDLE, commit strobe in RUN.
    // Starts seen while running are deliberately not decoded.
    always_comb begin
        w_accept = 1'b0;
        w_mthi   = 1'b0;
        w_mtlo   = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start && !flush) begin
                    w_accept = w_is_mul || w_is_div;
                    w_mthi   = (op == c_OP_MTHI);
                    w_mtlo   = (op == c_OP_MTLO);
                end
            end
            c_ST_RUN: begin
                w_commit = !flush && (r_cnt == 4'd1);
            end
            default: begin
                w_commit = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // Latency counter and pending result, loaded at the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= 4'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= w_cnt_load;
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_pend_wr <= w_res_wr;
        end else if (r_state == c_ST_RUN) begin
            if (w_state_next == c_ST_IDLE) begin
                r_cnt     <= 4'd0;
                r_pend_wr <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // HI/LO: written by a non-flushed commit or by mthi/mtlo in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (w_commit && r_pend_wr) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
            if (w_mthi) begin
                r_hi <= a;
            end
            if (w_mtlo) begin
                r_lo <= a;
            end
        end
    end

    // One-cycle completion pulse following the commit edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_commit;
        end
    end

    assign busy = (r_state == c_ST_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign done = r_done;

endmodule
`default_nettype wire
